// File: rtl/vga_text_pkg.sv
// Shared text-mode definitions: screen geometry defaults, blank cell value,
// character-sink FSM states and the capture FIFO entry layout.
package vga_text_pkg;

    localparam int          COLS_DEF   = 40;
    localparam int          ROWS_DEF   = 30;
    localparam int          FB_ADDR_W  = 11;
    localparam int          FIFO_D_DEF = 4;
    localparam logic [15:0] BLANK_DEF  = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_CLR_REQ,
        ST_CLR_WRITE
    } sink_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [15:0]          data;
    } fifo_entry_t;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO. A pop and a push on the same edge are both honoured,
// even when full; flush empties it and takes priority over both.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_char_sink.sv
// Captures CPU character strobes into a FIFO and writes them into frame memory
// over a req/gnt port shared with scanout; also runs full-screen clear sweeps.
module vga_char_sink
    import vga_text_pkg::*;
#(
    parameter int          COLS   = COLS_DEF,
    parameter int          ROWS   = ROWS_DEF,
    parameter int          ADDR_W = FB_ADDR_W,
    parameter int          FIFO_D = FIFO_D_DEF,
    parameter logic [15:0] BLANK  = BLANK_DEF
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    input  logic              videoflag,
    input  logic [15:0]       bus_vga_pos,
    input  logic [15:0]       bus_vga_char,
    input  logic              clear_req,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              busy,
    output logic [7:0]        drop_count
);

    localparam int                CELLS = COLS * ROWS;
    localparam int                CW    = $clog2(FIFO_D) + 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

    sink_state_e       state_q, state_d;
    logic              flag_q, flag_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]        drop_q, drop_d;

    logic              capture, in_range, push, pop, dropped;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    fifo_entry_t       push_entry, head;
    logic              clear_now;

    assign capture   = videoflag && !flag_q;
    assign in_range  = (bus_vga_pos < 16'(CELLS));
    assign pop       = (state_q == ST_WRITE);
    assign push      = capture && in_range && !clear_req;
    // A full FIFO still takes the push when the head is leaving on this edge.
    assign dropped   = capture && !clear_req && (!in_range || (fifo_full && !pop));
    assign clear_now = clr_pend_q || clear_req;

    assign push_entry.addr = FB_ADDR_W'(bus_vga_pos);
    assign push_entry.data = bus_vga_char;

    char_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (wire_clock),
        .rst   (wire_reset),
        .flush (clear_req),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        flag_d = videoflag;
        drop_d = drop_q;
        if (dropped && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            state_q    <= ST_IDLE;
            flag_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            flag_q     <= flag_d;
            clr_pend_q <= clr_pend_d;
            clr_cnt_q  <= clr_cnt_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_cnt_d  = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_now) begin
                    state_d    = ST_CLR_REQ;
                    clr_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The pending entry is flushed by a clear, so back off.
                if (clear_now) begin
                    state_d    = ST_IDLE;
                    clr_pend_d = 1'b1;
                end else if (mem_gnt) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                clr_pend_d = clear_now;
                if (!clear_now && (fifo_count > CW'(1) || push)) state_d = ST_REQ;
                else                                              state_d = ST_IDLE;
            end
            ST_CLR_REQ: begin
                if (clear_req) clr_cnt_d = '0;
                if (mem_gnt)   state_d   = ST_CLR_WRITE;
            end
            ST_CLR_WRITE: begin
                if (clear_req) begin
                    clr_cnt_d = '0;
                    state_d   = mem_gnt ? ST_CLR_WRITE : ST_CLR_REQ;
                end else if (clr_cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    state_d   = mem_gnt ? ST_CLR_WRITE : ST_CLR_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        case (state_q)
            ST_REQ, ST_CLR_REQ: mem_req = 1'b1;
            ST_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ADDR_W'(head.addr);
                mem_data = head.data;
            end
            ST_CLR_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
                mem_data = BLANK;
            end
            default: ;
        endcase
        busy       = (state_q != ST_IDLE) || !fifo_empty || clr_pend_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_vga_char_sink.sv
// Directed bench for vga_char_sink: strobe capture, FIFO overflow, range drop,
// clear sweeps (with and without grant gaps) and reset during a sweep.
module tb_vga_char_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        videoflag, clear_req, mem_gnt;
    logic [15:0] pos, chr;
    logic        mem_req, mem_we, busy;
    logic [10:0] mem_addr;
    logic [15:0] mem_data;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int req_cnt  = 0;
    int gnt_viol = 0;
    logic prev_ok = 1'b0;

    vga_char_sink dut (
        .wire_clock   (clk),
        .wire_reset   (rst),
        .videoflag    (videoflag),
        .bus_vga_pos  (pos),
        .bus_vga_char (chr),
        .clear_req    (clear_req),
        .mem_gnt      (mem_gnt),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log plus the rule that a write must follow a granted request cycle.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_data));
            wr_cyc.push_back(cyc);
            if (!prev_ok) gnt_viol++;
        end
        if (mem_req === 1'b1) req_cnt++;
        prev_ok = (mem_req === 1'b1) && (mem_gnt === 1'b1);
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        req_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; videoflag = 1'b0; clear_req = 1'b0; mem_gnt = 1'b0;
        pos = '0; chr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic strobe(input logic [15:0] p, input logic [15:0] c);
        pos = p; chr = c; videoflag = 1'b1;
        @(negedge clk);
        videoflag = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_data} !== '0) begin
            failures++;
            $display("FAIL reset_mem got req=%b we=%b addr=%0d data=%h want all 0", mem_req, mem_we, mem_addr, mem_data);
        end
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_status got busy=%b drop=%0d want 0 0", busy, drop_count);
        end
    endtask

    task automatic test_single_write();
        int c0;
        do_reset();
        mem_gnt = 1'b1;
        c0 = cyc;
        pos = 16'd10; chr = 16'h0041; videoflag = 1'b1;
        repeat (3) @(negedge clk);
        videoflag = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1) begin
            failures++; $display("FAIL single_count got %0d want 1", wr_addr.size());
        end
        checks++;
        if (wr_addr.size() < 1 || wr_addr[0] != 10 || wr_data[0] != 'h41) begin
            failures++; $display("FAIL single_content got addr=%0d data=%h want 10 0041",
                                 wr_addr.size() ? wr_addr[0] : -1, wr_data.size() ? wr_data[0] : -1);
        end
        checks++;
        if (wr_cyc.size() < 1 || wr_cyc[0] != c0 + 3) begin
            failures++; $display("FAIL single_latency got cycle=%0d want %0d",
                                 wr_cyc.size() ? wr_cyc[0] : -1, c0 + 3);
        end
    endtask

    task automatic test_back_to_back();
        int exp_a[5] = '{0, 1, 2, 3, 9};
        int bad_c, bad_g;
        do_reset();
        for (int i = 0; i < 6; i++) strobe(16'(i), 16'h0100 + 16'(i));
        repeat (8) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0 || busy !== 1'b1 || drop_count !== 8'd2) begin
            failures++; $display("FAIL overflow_hold got writes=%0d busy=%b drop=%0d want 0 1 2",
                                 wr_addr.size(), busy, drop_count);
        end
        // Strobe lands on the same edge as the first pop of a full FIFO.
        mem_gnt = 1'b1;
        @(negedge clk);
        strobe(16'd9, 16'h0109);
        for (int i = 0; i < 60 && busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL drain_timeout got busy=%b want 0", busy);
        end
        checks++;
        if (wr_addr.size() != 5 || drop_count !== 8'd2) begin
            failures++; $display("FAIL drain_count got writes=%0d drop=%0d want 5 2", wr_addr.size(), drop_count);
        end
        bad_c = 0; bad_g = 0;
        for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
            if (wr_addr[i] != exp_a[i] || wr_data[i] != ('h100 + exp_a[i])) bad_c++;
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 2) bad_g++;
        end
        checks++;
        if (bad_c != 0) begin
            failures++; $display("FAIL drain_order got %0d bad entries want 0", bad_c);
        end
        checks++;
        if (bad_g != 0) begin
            failures++; $display("FAIL drain_rate got %0d gaps not 2 cycles want 0", bad_g);
        end
    endtask

    task automatic test_range();
        do_reset();
        mem_gnt = 1'b1;
        strobe(16'd1200, 16'h5555);
        repeat (6) @(negedge clk);
        checks++;
        if (req_cnt != 0 || wr_addr.size() != 0 || drop_count !== 8'd1) begin
            failures++; $display("FAIL range_drop got req=%0d writes=%0d drop=%0d want 0 0 1",
                                 req_cnt, wr_addr.size(), drop_count);
        end
        strobe(16'd1199, 16'h7E7E);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != 1199 || wr_data[0] != 'h7E7E || drop_count !== 8'd1) begin
            failures++; $display("FAIL range_last got writes=%0d addr=%0d drop=%0d want 1 1199 1",
                                 wr_addr.size(), wr_addr.size() ? wr_addr[0] : -1, drop_count);
        end
    endtask

    task automatic test_clear_sweep();
        int bad;
        do_reset();
        mem_gnt = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1400 && busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL sweep_done got busy=%b req=%b want 0 0", busy, mem_req);
        end
        checks++;
        if (wr_addr.size() != 1200) begin
            failures++; $display("FAIL sweep_count got %0d want 1200", wr_addr.size());
        end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] != 0 || wr_cyc[i] != wr_cyc[0] + i) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL sweep_seq got %0d bad cells want 0", bad);
        end
    endtask

    task automatic test_clear_toggle();
        int bad;
        do_reset();
        strobe(16'd5, 16'hAAAA);
        strobe(16'd6, 16'hBBBB);
        // Capture and clear on one edge: the clear must win.
        pos = 16'd7; chr = 16'hCCCC; videoflag = 1'b1; clear_req = 1'b1;
        @(negedge clk);
        videoflag = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 3000 && busy === 1'b1; i++) begin
            mem_gnt = ~mem_gnt;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL toggle_done got busy=%b want 0", busy);
        end
        checks++;
        if (wr_addr.size() != 1200 || drop_count !== 8'd0) begin
            failures++; $display("FAIL toggle_count got writes=%0d drop=%0d want 1200 0", wr_addr.size(), drop_count);
        end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != i || wr_data[i] != 0) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL toggle_seq got %0d bad cells want 0", bad);
        end
        checks++;
        if (gnt_viol != 0) begin
            failures++; $display("FAIL toggle_grant got %0d ungranted writes want 0", gnt_viol);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found = 1'b0;
        do_reset();
        mem_gnt = 1'b1;
        strobe(16'd2000, 16'h0000);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (mem_we === 1'b1 && mem_addr === 11'd500) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL mid_reach got found=%0d want 1", found);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || mem_req !== 1'b0 || drop_count !== 8'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset got we=%b req=%b drop=%0d busy=%b want 0 0 0 0",
                                 mem_we, mem_req, drop_count, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        strobe(16'd3, 16'h1234);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != 3 || wr_data[0] != 'h1234) begin
            failures++; $display("FAIL mid_recover got writes=%0d addr=%0d want 1 3",
                                 wr_addr.size(), wr_addr.size() ? wr_addr[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_range();
        test_clear_sweep();
        test_clear_toggle();
        test_reset_mid_sweep();
        checks++;
        if (gnt_viol != 0) begin
            failures++; $display("FAIL grant_rule got %0d ungranted writes want 0", gnt_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
